// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/LSU arbiter for a single-port memory bus with LSU fairness limit and response timeout
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  input  logic                  lsu_req,
  input  logic                  lsu_we,
  input  logic [DATA_W/8-1:0]   lsu_be,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic [DATA_W-1:0]     lsu_wdata,
  output logic                  lsu_gnt,
  output logic                  lsu_rvalid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam int SW   = $clog2(MAX_STREAK + 1);
  localparam int TW   = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state;
  logic          owner_lsu;
  logic [SW-1:0] streak;
  logic [TW-1:0] timer;

  logic sel_lsu;
  logic req_on;
  logic gnt;
  logic rsp;
  logic timeout_hit;

  // Arbitration happens only in IDLE; REQ replays the latched owner.
  always_comb begin
    sel_lsu = owner_lsu;
    req_on  = 1'b0;
    if (state == IDLE) begin
      sel_lsu = lsu_req && !(if_req && (streak == SW'(MAX_STREAK)));
      req_on  = if_req || lsu_req;
    end else if (state == REQ) begin
      req_on = 1'b1;
    end
    req_on = req_on && rst_n;
  end

  assign gnt         = req_on && mem_gnt;
  assign timeout_hit = (TIMEOUT != 0) && (state == WAIT) && !mem_rvalid &&
                       (timer == TW'(TIMEOUT - 1));
  assign rsp         = rst_n && (state == WAIT) && (mem_rvalid || timeout_hit);

  always_comb begin
    mem_req   = req_on;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (req_on) begin
      if (sel_lsu) begin
        mem_we    = lsu_we;
        mem_be    = lsu_be;
        mem_addr  = lsu_addr;
        mem_wdata = lsu_wdata;
      end else begin
        mem_be    = {BE_W{1'b1}};
        mem_addr  = if_addr;
      end
    end
  end

  assign if_gnt     = gnt && !sel_lsu;
  assign lsu_gnt    = gnt && sel_lsu;
  assign if_rvalid  = rsp && !owner_lsu;
  assign lsu_rvalid = rsp && owner_lsu;
  assign rsp_rdata  = (rsp && mem_rvalid) ? mem_rdata : '0;
  assign rsp_err    = rsp && !mem_rvalid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner_lsu <= 1'b0;
      streak    <= '0;
      timer     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_on) begin
            owner_lsu <= sel_lsu;
            if (mem_gnt) begin
              state <= WAIT;
              timer <= '0;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            state <= WAIT;
            timer <= '0;
          end
        end
        WAIT: begin
          if (rsp) state <= IDLE;
          else     timer <= timer + TW'(1);
        end
        default: state <= IDLE;
      endcase

      // Streak counts LSU grants that overtook a waiting fetch.
      if (!if_req || if_gnt) begin
        streak <= '0;
      end else if (lsu_gnt && (streak != SW'(MAX_STREAK))) begin
        streak <= streak + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic        lsu_req;
  logic        lsu_we;
  logic [3:0]  lsu_be;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_gnt;
  logic        lsu_rvalid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_be(lsu_be), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mem_req"},    mem_req,    0);
    chk({tag, ".mem_addr"},   mem_addr,   0);
    chk({tag, ".mem_be"},     mem_be,     0);
    chk({tag, ".if_gnt"},     if_gnt,     0);
    chk({tag, ".lsu_gnt"},    lsu_gnt,    0);
    chk({tag, ".if_rvalid"},  if_rvalid,  0);
    chk({tag, ".lsu_rvalid"}, lsu_rvalid, 0);
    chk({tag, ".rsp_rdata"},  rsp_rdata,  0);
    chk({tag, ".rsp_err"},    rsp_err,    0);
  endtask

  int exp_l[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h10;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_be = 4'h0; lsu_addr = 32'h0; lsu_wdata = 32'h0;
    mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    step(); step();
    sample();
    chk_all_zero("reset");

    // 1: fetch only, response two cycles after grant
    step();
    rst_n = 1'b1; if_req = 1'b1; if_addr = 32'h40; mem_gnt = 1'b1;
    sample();
    chk("t1.if_gnt", if_gnt, 1);
    chk("t1.lsu_gnt", lsu_gnt, 0);
    chk("t1.mem_addr", mem_addr, 32'h40);
    chk("t1.mem_be", mem_be, 4'hf);
    chk("t1.mem_we", mem_we, 0);
    step();
    if_req = 1'b0; mem_gnt = 1'b0;
    sample();
    chk("t1.wait_mem_req", mem_req, 0);
    chk("t1.wait_if_rvalid", if_rvalid, 0);
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    sample();
    chk("t1.if_rvalid", if_rvalid, 1);
    chk("t1.lsu_rvalid", lsu_rvalid, 0);
    chk("t1.rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("t1.rsp_err", rsp_err, 0);

    // 2: simultaneous requests, LSU store wins
    step();
    mem_rvalid = 1'b0; mem_gnt = 1'b1;
    if_req = 1'b1; if_addr = 32'h80;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_be = 4'h3; lsu_addr = 32'h100; lsu_wdata = 32'h1234;
    sample();
    chk("t2.lsu_gnt", lsu_gnt, 1);
    chk("t2.if_gnt", if_gnt, 0);
    chk("t2.mem_we", mem_we, 1);
    chk("t2.mem_be", mem_be, 4'h3);
    chk("t2.mem_addr", mem_addr, 32'h100);
    chk("t2.mem_wdata", mem_wdata, 32'h1234);
    step();
    lsu_req = 1'b0;
    sample();
    chk("t2.wait_if_gnt", if_gnt, 0);
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h0;
    sample();
    chk("t2.lsu_rvalid", lsu_rvalid, 1);
    chk("t2.rsp_if_gnt", if_gnt, 0);
    step();
    mem_rvalid = 1'b0;
    sample();
    chk("t2.if_gnt_after", if_gnt, 1);
    chk("t2.if_mem_addr", mem_addr, 32'h80);
    step();
    if_req = 1'b0; mem_gnt = 1'b0;
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h11;
    sample();
    chk("t2.if_rvalid", if_rvalid, 1);
    step();
    mem_rvalid = 1'b0;

    // 3: both requesting continuously, streak limit of 4
    if_req = 1'b1; if_addr = 32'h200;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_be = 4'hf; lsu_addr = 32'h300; lsu_wdata = 32'h0;
    mem_gnt = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sample();
      chk($sformatf("t3.lsu_gnt[%0d]", i), lsu_gnt, exp_l[i]);
      chk($sformatf("t3.if_gnt[%0d]", i), if_gnt, 64'(exp_l[i] == 0));
      step();
      mem_rvalid = 1'b1;
      step();
      mem_rvalid = 1'b0;
    end
    if_req = 1'b0; lsu_req = 1'b0; mem_gnt = 1'b0;
    step();

    // 4: fetch stalled in REQ, LSU arrives meanwhile
    if_req = 1'b1; if_addr = 32'h200; mem_gnt = 1'b0;
    sample();
    chk("t4.c1_if_gnt", if_gnt, 0);
    chk("t4.c1_mem_addr", mem_addr, 32'h200);
    step();
    lsu_req = 1'b1; lsu_addr = 32'h300; lsu_we = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      sample();
      chk($sformatf("t4.c%0d_mem_addr", c), mem_addr, 32'h200);
      chk($sformatf("t4.c%0d_lsu_gnt", c), lsu_gnt, 0);
      chk($sformatf("t4.c%0d_if_gnt", c), if_gnt, 0);
      step();
    end
    mem_gnt = 1'b1;
    sample();
    chk("t4.c6_if_gnt", if_gnt, 1);
    chk("t4.c6_lsu_gnt", lsu_gnt, 0);
    step();
    if_req = 1'b0; mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h55;
    sample();
    chk("t4.if_rvalid", if_rvalid, 1);
    chk("t4.rsp_rdata", rsp_rdata, 32'h55);

    // 5: LSU load with no response times out on the 64th WAIT cycle
    step();
    mem_rvalid = 1'b0; mem_gnt = 1'b1;
    sample();
    chk("t5.lsu_gnt", lsu_gnt, 1);
    chk("t5.mem_addr", mem_addr, 32'h300);
    step();
    lsu_req = 1'b0; mem_gnt = 1'b0;
    for (int w = 1; w < 64; w++) begin
      sample();
      chk($sformatf("t5.w%0d_lsu_rvalid", w), lsu_rvalid, 0);
      step();
    end
    sample();
    chk("t5.to_lsu_rvalid", lsu_rvalid, 1);
    chk("t5.to_rsp_err", rsp_err, 1);
    chk("t5.to_rsp_rdata", rsp_rdata, 0);
    chk("t5.to_if_rvalid", if_rvalid, 0);
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h99;
    sample();
    chk("t5.late_lsu_rvalid", lsu_rvalid, 0);
    chk("t5.late_if_rvalid", if_rvalid, 0);
    step();
    mem_rvalid = 1'b0;

    // 6: reset during WAIT abandons the transaction
    if_req = 1'b1; if_addr = 32'h600; mem_gnt = 1'b1;
    sample();
    chk("t6.if_gnt", if_gnt, 1);
    step();
    if_req = 1'b0; mem_gnt = 1'b0;
    step();
    rst_n = 1'b0; if_req = 1'b1;
    step();
    sample();
    chk_all_zero("t6.rst");
    step();
    rst_n = 1'b1; if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1;
    sample();
    chk("t6.stray_if_rvalid", if_rvalid, 0);
    chk("t6.stray_lsu_rvalid", lsu_rvalid, 0);
    chk("t6.stray_mem_req", mem_req, 0);
    step();
    mem_rvalid = 1'b0; mem_gnt = 1'b1;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_be = 4'hf; lsu_addr = 32'h400;
    sample();
    chk("t6.lsu_gnt", lsu_gnt, 1);
    step();
    lsu_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5;
    sample();
    chk("t6.lsu_rvalid", lsu_rvalid, 1);
    chk("t6.lsu_rdata", rsp_rdata, 32'hA5A5);
    step();
    mem_rvalid = 1'b0; mem_gnt = 1'b1; if_req = 1'b1; if_addr = 32'h500;
    sample();
    chk("t6.if_gnt2", if_gnt, 1);
    chk("t6.if_mem_addr", mem_addr, 32'h500);
    step();
    if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77;
    sample();
    chk("t6.if_rvalid", if_rvalid, 1);
    chk("t6.if_rdata", rsp_rdata, 32'h77);
    step();
    mem_rvalid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
